// File: rtl/testcard_pkg.sv
// Shared test-card types and colour constants, parametrised on bits per channel.
// Pure constants and functions; no clocked logic, so no latency or backpressure.
package testcard_pkg;

    typedef enum logic [2:0] {
        TC_STD   = 3'd0,
        TC_BARS  = 3'd1,
        TC_CHECK = 3'd2,
        TC_WHITE = 3'd3,
        TC_MOVE  = 3'd4
    } tc_mode_e;

    // Bar order: red, green, blue, magenta, yellow, cyan, white, orange.
    function automatic logic [31:0] tc_bar_color(input int idx, input int cw);
        int full;
        int half;
        int r;
        int g;
        int b;
        full = (1 << cw) - 1;
        half = 1 << (cw - 1);
        r = 0;
        g = 0;
        b = 0;
        case (idx)
            0:       r = full;
            1:       g = full;
            2:       b = full;
            3:       begin r = full; b = full; end
            4:       begin r = full; g = full; end
            5:       begin g = full; b = full; end
            6:       begin r = full; g = full; b = full; end
            default: begin r = full; g = half; end
        endcase
        return 32'((r << (2 * cw)) | (g << cw) | b);
    endfunction

    function automatic logic [31:0] tc_mid_grey(input int cw);
        int c;
        c = (1 << (cw - 1)) - 1;
        return 32'((c << (2 * cw)) | (c << cw) | c);
    endfunction

endpackage

// File: rtl/tc_segment_counter.sv
// Splits an active line into SEGMENTS runs of SPAN pixels; remainder joins the last run.
// seg is combinational from state (restart forces 0 the same cycle); no backpressure.
module tc_segment_counter #(
    parameter int SEGMENTS = 8,
    parameter int SPAN     = 100,
    localparam int SW      = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          adv,
    output logic [SW-1:0] seg
);
    localparam int CW = $clog2(SPAN + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_cur;
    logic [SW-1:0] seg_q, seg_d;

    always_comb begin
        cnt_cur = restart ? '0 : cnt_q;
        seg     = restart ? '0 : seg_q;
        cnt_d   = cnt_cur;
        seg_d   = seg;
        if (adv) begin
            if (cnt_cur == CW'(SPAN - 1)) begin
                cnt_d = '0;
                if (seg != SW'(SEGMENTS - 1)) begin
                    seg_d = seg + 1'b1;
                end
            end else begin
                cnt_d = cnt_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            cnt_q <= '0;
            seg_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            seg_q <= seg_d;
        end
    end

endmodule

// File: rtl/testcard_gen.sv
// Video test-pattern generator; TESTCARD_ANIM_EN adds the moving-bar mode and frame counter.
// One cycle registered latency from x/y/de to pixel; free-running stream, no backpressure.
module testcard_gen
    import testcard_pkg::*;
#(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int HDE_START = 270,
    parameter int VDE_START = 34,
    parameter int XW        = 11,
    parameter int YW        = 10,
    parameter int COLOR_W   = 4,
    parameter int DBG_W     = 64,
    parameter int DBG_ROWS  = 32,
    parameter int MOV_W     = 16,
    parameter int MOV_STEP  = 4
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    input  logic [XW-1:0]        x_cnt,
    input  logic [YW-1:0]        y_cnt,
    input  logic                 hsync_de,
    input  logic                 vsync_de,
    input  logic [2:0]           mode,
    input  logic [DBG_W-1:0]     dbg,
    output logic [3*COLOR_W-1:0] bar_data,
    output logic                 pix_valid,
    output logic                 frame_start
);
    localparam int PW  = 3 * COLOR_W;
    localparam int SWW = $clog2(PW);
    localparam int SDW = $clog2(DBG_W + 1);

    logic [XW-1:0]    xo;
    logic [YW-1:0]    yo;
    logic             active, fs;
    logic [2:0]       mode_q, mode_d, mode_eff;
    logic [DBG_W-1:0] dbg_q, dbg_d, dbg_eff;
    logic [PW-1:0]    bar_data_q, bar_data_d, std_pix, pix;
    logic             pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic [2:0]       seg_bar;
    logic [SWW-1:0]   seg_walk;
    logic [SDW-1:0]   seg_dbg;

    assign xo       = x_cnt - XW'(HDE_START);
    assign yo       = y_cnt - YW'(VDE_START);
    assign active   = hsync_de & vsync_de;
    assign fs       = (x_cnt == XW'(HDE_START)) && (y_cnt == YW'(VDE_START));
    assign mode_eff = fs ? mode : mode_q;
    assign dbg_eff  = fs ? dbg : dbg_q;

    tc_segment_counter #(.SEGMENTS(8), .SPAN(H_ACTIVE / 8)) u_seg_bar (
        .vga_clk(vga_clk), .reset(reset), .restart(xo == '0), .adv(active), .seg(seg_bar)
    );
    tc_segment_counter #(.SEGMENTS(PW), .SPAN(H_ACTIVE / PW)) u_seg_walk (
        .vga_clk(vga_clk), .reset(reset), .restart(xo == '0), .adv(active), .seg(seg_walk)
    );
    // One extra segment soaks up the pixels past the last debug cell and renders black.
    tc_segment_counter #(.SEGMENTS(DBG_W + 1), .SPAN(H_ACTIVE / DBG_W)) u_seg_dbg (
        .vga_clk(vga_clk), .reset(reset), .restart(xo == '0), .adv(active), .seg(seg_dbg)
    );

`ifdef TESTCARD_ANIM_EN
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [XW-1:0] pos_q, pos_d, pos_eff;
    logic [XW:0]   pos_sum, mov_end;
    logic          mov_hit;
    logic          unused_frame_cnt;

    assign unused_frame_cnt = ^frame_cnt_q;

    always_comb begin
        pos_sum     = {1'b0, pos_q} + (XW+1)'(MOV_STEP);
        pos_eff     = pos_q;
        frame_cnt_d = frame_cnt_q;
        if (fs) begin
            pos_eff     = (pos_sum >= (XW+1)'(H_ACTIVE)) ? '0 : pos_sum[XW-1:0];
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        pos_d   = pos_eff;
        mov_end = {1'b0, pos_eff} + (XW+1)'(MOV_W);
        mov_hit = (xo >= pos_eff) && ({1'b0, xo} < mov_end) && (xo < XW'(H_ACTIVE));
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            pos_q       <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            pos_q       <= pos_d;
        end
    end
`endif

    always_comb begin
        if (yo < YW'(V_ACTIVE / 2)) begin
            std_pix = PW'(tc_bar_color(int'(seg_bar), COLOR_W));
        end else if (yo < YW'(V_ACTIVE - DBG_ROWS)) begin
            std_pix = PW'(1) << (PW - 1 - int'(seg_walk));
        end else begin
            std_pix = |(dbg_eff & (DBG_W'(1) << seg_dbg)) ? PW'(tc_mid_grey(COLOR_W)) : '0;
        end

        case (mode_eff)
            TC_BARS:  pix = PW'(tc_bar_color(int'(seg_bar), COLOR_W));
            TC_CHECK: pix = (xo[5] ^ yo[5]) ? '1 : '0;
            TC_WHITE: pix = '1;
`ifdef TESTCARD_ANIM_EN
            TC_MOVE:  pix = mov_hit ? '1 : '0;
`endif
            default:  pix = std_pix;
        endcase

        bar_data_d    = active ? pix : '0;
        pix_valid_d   = active;
        frame_start_d = fs;
        mode_d        = mode_eff;
        dbg_d         = dbg_eff;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            bar_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            mode_q        <= '0;
            dbg_q         <= '0;
        end else begin
            bar_data_q    <= bar_data_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            mode_q        <= mode_d;
            dbg_q         <= dbg_d;
        end
    end

    assign bar_data    = bar_data_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_testcard_gen.sv
// Bench for testcard_gen: directed lines with literal pixel expectations plus random
// lines, all compared every cycle against a division-based model of the test card.
module tb_testcard_gen;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x_cnt = '0;
    logic [9:0]  y_cnt = '0;
    logic        hsync_de = 1'b0;
    logic        vsync_de = 1'b0;
    logic [2:0]  mode = '0;
    logic [63:0] dbg = '0;
    logic [11:0] bar_data;
    logic        pix_valid;
    logic        frame_start;

    testcard_gen dut (
        .vga_clk(vga_clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .hsync_de(hsync_de), .vsync_de(vsync_de), .mode(mode), .dbg(dbg),
        .bar_data(bar_data), .pix_valid(pix_valid), .frame_start(frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;
    bit chk_pix = 1'b1;
    int line_buf[800];

    int          m_mode = 0;
    logic [63:0] m_dbg = '0;
    int          m_frames = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bar_col(input int k);
        case (k)
            0: return 'hF00;
            1: return 'h0F0;
            2: return 'h00F;
            3: return 'hF0F;
            4: return 'hFF0;
            5: return 'h0FF;
            6: return 'hFFF;
            default: return 'hF80;
        endcase
    endfunction

    // Pixel colour from the card description, using plain division on the offsets.
    function automatic int model_pix(input int xo, input int yo, input int m,
                                     input logic [63:0] d, input int pos);
        int k;
`ifdef TESTCARD_ANIM_EN
        if (m == 4) return (xo >= pos && xo < pos + 16 && xo < 800) ? 'hFFF : 0;
`else
        if (pos < 0) return 0;
`endif
        if (m == 1 || (m != 2 && m != 3 && yo < 300)) begin
            k = xo / 100;
            if (k > 7) k = 7;
            return bar_col(k);
        end
        if (m == 2) return (((xo / 32) + (yo / 32)) % 2 == 1) ? 'hFFF : 0;
        if (m == 3) return 'hFFF;
        if (yo < 568) begin
            k = xo / 66;
            if (k > 11) k = 11;
            return 1 << (11 - k);
        end
        k = xo / 12;
        if (k < 64 && ((d >> k) & 64'd1) != 64'd0) return 'h777;
        return 0;
    endfunction

    always begin : cmp
        int xo, yo, e_pix, e_val, e_fs;
        bit e_chk, e_rst;
        @(posedge vga_clk);
        xo = (int'(x_cnt) - 270 + 2048) % 2048;
        yo = (int'(y_cnt) - 34 + 1024) % 1024;
        e_rst = reset;
        if (reset) begin
            m_mode = 0; m_dbg = '0; m_frames = 0;
            e_pix = 0; e_val = 0; e_fs = 0; e_chk = 1'b1;
        end else begin
            e_fs = (int'(x_cnt) == 270 && int'(y_cnt) == 34) ? 1 : 0;
            if (e_fs == 1) begin
                m_mode = int'(mode);
                m_dbg = dbg;
                m_frames++;
            end
            e_val = (hsync_de && vsync_de) ? 1 : 0;
            e_pix = (e_val == 1) ? model_pix(xo, yo, m_mode, m_dbg, (m_frames * 4) % 800) : 0;
            e_chk = chk_pix || (e_val == 0);
        end
        @(negedge vga_clk);
        check("pix_valid", int'(pix_valid), e_val);
        check("frame_start", int'(frame_start), e_fs);
        if (e_chk) check($sformatf("bar_data xo=%0d yo=%0d", xo, yo), int'(bar_data), e_pix);
        if (e_val == 1 && !e_rst && xo < 800) line_buf[xo] = int'(bar_data);
    end

    task automatic cyc(input int x, input int y, input bit h, input bit v, input bit c);
        @(posedge vga_clk);
        #1;
        x_cnt = 11'(x);
        y_cnt = 10'(y);
        hsync_de = h;
        vsync_de = v;
        chk_pix = c;
    endtask

    task automatic blank_rnd();
        bit h;
        h = 1'($urandom);
        cyc($urandom_range(0, 2047), $urandom_range(0, 1023), h, h ? 1'b0 : 1'($urandom), 1'b1);
    endtask

    // Full active line at offset yo; optional noise on mode/dbg to prove they are latched.
    task automatic line(input int yo, input bit noise);
        for (int i = 0; i < 800; i++) line_buf[i] = -1;
        for (int xo = 0; xo < 800; xo++) begin
            cyc(xo + 270, yo + 34, 1'b1, 1'b1, 1'b1);
            if (noise) begin
                mode = 3'($urandom);
                dbg = {$urandom, $urandom};
            end
        end
        cyc(0, 0, 1'b0, 1'b0, 1'b1);
        @(negedge vga_clk);
        #1;
    endtask

    task automatic frame_pulse(input int m, input logic [63:0] d);
        cyc(270, 34, 1'b1, 1'b1, 1'b1);
        mode = 3'(m);
        dbg = d;
        cyc(0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic lb(input string name, input int xo, input int exp);
        check(name, line_buf[xo], exp);
    endtask

    initial begin
        repeat (3) cyc(0, 0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;

        check("model bar 0F0", model_pix(100, 10, 0, '0, 0), 'h0F0);
        check("model walk 001", model_pix(792, 400, 0, '0, 0), 'h001);
        check("model dbg cell1", model_pix(12, 590, 0, 64'h1, 0), 0);

        frame_pulse(0, 64'h1);
        line(10, 1'b1);
        lb("y10 xo0", 0, 'hF00);
        lb("y10 xo99", 99, 'hF00);
        lb("y10 xo100", 100, 'h0F0);
        lb("y10 xo700", 700, 'hF80);
        lb("y10 xo799", 799, 'hF80);
        line(400, 1'b1);
        lb("y400 xo0", 0, 'h800);
        lb("y400 xo725", 725, 'h002);
        lb("y400 xo792", 792, 'h001);
        lb("y400 xo799", 799, 'h001);
        mode = 3'd0;
        dbg = '1;
        line(590, 1'b0);
        lb("dbg1 xo0", 0, 'h777);
        lb("dbg1 xo11", 11, 'h777);
        lb("dbg1 xo12", 12, 'h000);
        frame_pulse(0, '1);
        line(590, 1'b0);
        lb("dbgall xo12", 12, 'h777);
        lb("dbgall xo767", 767, 'h777);
        lb("dbgall xo768", 768, 'h000);

        frame_pulse(2, '0);
        line(0, 1'b0);
        lb("chk y0 xo32", 32, 'hFFF);
        lb("chk y0 xo0", 0, 'h000);
        line(32, 1'b0);
        lb("chk y32 xo32", 32, 'h000);
        lb("chk y32 xo0", 0, 'hFFF);

        repeat (30) blank_rnd();

        for (int xo = 0; xo < 800; xo++) begin
            cyc(xo + 270, 44, 1'b1, 1'b1, xo < 400);
            reset = (xo == 400);
        end
        cyc(0, 0, 1'b0, 1'b0, 1'b1);
        line(10, 1'b0);
        lb("post-reset mode0 xo0", 0, 'hF00);
        lb("post-reset mode0 xo100", 100, 'h0F0);

        frame_pulse(4, '0);
        line(100, 1'b0);
`ifdef TESTCARD_ANIM_EN
        lb("mov f1 xo3", 3, 'h000);
        lb("mov f1 xo4", 4, 'hFFF);
        lb("mov f1 xo19", 19, 'hFFF);
        lb("mov f1 xo20", 20, 'h000);
`else
        lb("mode4 as std xo0", 0, 'hF00);
        lb("mode4 as std xo700", 700, 'hF80);
`endif
        repeat (198) frame_pulse(4, '0);
        line(100, 1'b0);
`ifdef TESTCARD_ANIM_EN
        lb("mov f199 xo795", 795, 'h000);
        lb("mov f199 xo796", 796, 'hFFF);
        lb("mov f199 xo799", 799, 'hFFF);
`endif
        frame_pulse(4, '0);
        line(100, 1'b0);
`ifdef TESTCARD_ANIM_EN
        lb("mov f200 xo0", 0, 'hFFF);
        lb("mov f200 xo15", 15, 'hFFF);
        lb("mov f200 xo16", 16, 'h000);
`endif

        repeat (40) begin
            if ($urandom_range(0, 2) == 0) frame_pulse($urandom_range(0, 7), {$urandom, $urandom});
            line($urandom_range(0, 599), 1'b1);
            repeat ($urandom_range(0, 5)) blank_rnd();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/testcard_gen.md
# testcard_gen

Parametrised video test-pattern generator driven by the timing generator's x/y counters and data-enable strobes. It produces one RGB pixel per `vga_clk` with one cycle of registered latency. It supports several selectable patterns, a per-frame snapshot of a debug word rendered as a bit strip, and an optional animated pattern. It sits between the video timing block and the output DAC or OSD mixer.

## Interface
- `H_ACTIVE`, 800, active pixels per line
- `V_ACTIVE`, 600, active lines per frame
- `HDE_START`, 270, `x_cnt` value of first active pixel
- `VDE_START`, 34, `y_cnt` value of first active line
- `XW` / `YW`, 11 / 10, counter widths
- `COLOR_W`, 4, bits per channel; `bar_data` is `3*COLOR_W` wide, ordered R,G,B from MSB
- `DBG_W`, 64, debug word width (power of two)
- `DBG_ROWS`, 32, height in lines of the debug strip
- `MOV_W` / `MOV_STEP`, 16 / 4, moving bar width and per-frame advance in pixels
- `vga_clk`, in, 1, pixel clock; all logic on the rising edge
- `reset`, in, 1, synchronous, active-high
- `x_cnt`, in, XW, horizontal counter
- `y_cnt`, in, YW, vertical counter
- `hsync_de`, in, 1, horizontal active
- `vsync_de`, in, 1, vertical active
- `mode`, in, 3, pattern select
- `dbg`, in, DBG_W, debug word
- `bar_data`, out, 3*COLOR_W, pixel colour
- `pix_valid`, out, 1, registered `hsync_de & vsync_de`
- `frame_start`, out, 1, one-cycle pulse aligned with the first active pixel

## Operation
- `xo = x_cnt - HDE_START` and `yo = y_cnt - VDE_START` are computed XW/YW bits wide, wrapping.
- Active means `hsync_de & vsync_de`. When inactive, `bar_data` is 0.
- Frame start is the cycle where `x_cnt==HDE_START && y_cnt==VDE_START`. On that cycle:
  - `mode_q` takes `mode`.
  - `dbg_q` takes `dbg`.
  - `frame_cnt` increments.
  - The moving-bar position updates.
  - The pixel produced on that cycle already uses the new `mode` and `dbg`.
- Colour bars use a segment sub-module in place of comparators:
  - `seg` clears at `xo==0`.
  - An inner counter counts to `H_ACTIVE/N - 1`, then `seg` increments, saturating at `N-1`.
  - Remainder pixels belong to the last segment.
- Mode 0, standard card:
  - `yo < V_ACTIVE/2`: 8 bars in order red, green, blue, magenta, yellow, cyan, white, orange (R full, G = MSB only).
  - `yo < V_ACTIVE-DBG_ROWS`: `3*COLOR_W` walking-one bars; bar k outputs `1 << (3*COLOR_W-1-k)`.
  - Otherwise: debug strip. Cell width is `H_ACTIVE/DBG_W`; bit 0 is leftmost. A set bit gives mid-grey (each channel MSB=0, other bits 1); a clear bit gives black. Pixels beyond `DBG_W` cells are black.
- Mode 1: the 8 colour bars full height.
- Mode 2: checkerboard of 32×32 cells; white where `xo[5]^yo[5]`, else black.
- Mode 3: solid white.
- Mode 4: moving bar (see Configuration).
- Modes 5–7 behave as mode 0.

## Timing
- Latency is 1 cycle: `bar_data`, `pix_valid` and `frame_start` at edge n+1 reflect inputs sampled at edge n.
- Reset values:
  - `bar_data`=0, `pix_valid`=0, `frame_start`=0.
  - `mode_q`=0, `dbg_q`=0, `frame_cnt`=0, `pos`=0.
  - Segment counters = 0.
- Reset mid-line: outputs are 0 the next cycle. Generation resumes normally at the next `xo==0`. `mode_q` stays 0 until the next frame start.
- `mode` and `dbg` changes mid-frame have no effect until the next frame start.
- Moving bar position: `pos` advances by `MOV_STEP` each frame start. If `pos + MOV_STEP >= H_ACTIVE`, `pos` becomes 0.
- Moving bar pixel is white when `pos <= xo < pos+MOV_W`; the bar is clipped at `H_ACTIVE`.

## Configuration
- `TESTCARD_ANIM_EN` defined:
  - `frame_cnt` (16 bits, wrapping) and `pos` logic are present.
  - Mode 4 renders the moving bar.
- `TESTCARD_ANIM_EN` undefined:
  - No frame counter or position registers are built.
  - Mode 4 behaves as mode 0.
  - `frame_start` is still generated.

## Structure
- `testcard_pkg` holds:
  - The mode enum `TC_STD`, `TC_BARS`, `TC_CHECK`, `TC_WHITE`, `TC_MOVE`.
  - The 8-bar colour table as a function of `COLOR_W`.
  - The mid-grey constant function.
- Sub-module `tc_segment_counter`:
  - Parameters: `SEGMENTS`, `SPAN`.
  - Inputs: `vga_clk`, `reset`, `restart`, `adv`.
  - Output: `seg`.
  - Instantiated once for the 8-bar table, once for the walking-one table and once for the debug cells.

## Test plan
- Mode 0, default params, line with `yo=10`: `bar_data` is `0xF00` for `xo` 0–99, `0x0F0` at `xo=100`, `0xF80` for `xo` 700–799, each observed one cycle after the input.
- Mode 0, `yo=400`: `0x800` at `xo=0`, `0x001` at `xo=792`; remainder pixels 792–799 stay `0x001`.
- Debug strip: `dbg=64'h1` latched at frame start, `yo=590`: `0x777` for `xo` 0–11, `0x000` at `xo=12`. `dbg` changed mid-frame to all-ones leaves the frame unchanged; the next frame shows all cells `0x777`.
- Blanking: `hsync_de=0` with any x/y gives `bar_data=0`, `pix_valid=0`. Reset asserted mid-line gives all outputs 0 on the next cycle.
- `mode=4` with `TESTCARD_ANIM_EN`:
  - Frame 1 shows white at `xo` 4–19.
  - After 200 frames `pos` wraps to 0.
  - Without the macro, output matches mode 0.
- `mode=2`: `xo=32, yo=0` gives white; `xo=32, yo=32` gives black.
